// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: RX FIFO command front end driving the register block, with readback and status to the TX FIFO
module reg_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_fifo_data,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rd_en,
  output logic [31:0] tx_fifo_data,
  output logic        tx_fifo_wr_en,
  input  logic        tx_fifo_full,
  output logic [31:0] reg_rx_data,
  output logic        reg_num_le,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_tx_data,
  input  logic        reg_illegal_num,
  output logic        busy,
  output logic        cmd_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, ADDR, CHECK, WDATA, INC, RD, RCAP, FLUSH, STATUS} state_t;
  state_t state;
  logic [1:0] op;
  logic [CNT_W-1:0] n, done, left, done_nx;
  logic [31:0] cur;
  logic [3:0] err;
  logic [TW-1:0] tmo_cnt;
  logic rx_ok, tx_ok, pop, tmo, is_inc, is_rcap, st_push;
  assign rx_ok = !rx_fifo_empty && !reset;
  assign tx_ok = !tx_fifo_full && !reset;
  assign pop = rx_ok && (state == IDLE || state == ADDR || state == WDATA || state == FLUSH);
  assign tmo = rx_fifo_empty && (state == ADDR || state == WDATA || state == FLUSH)
               && tmo_cnt >= TW'(TIMEOUT_CYCLES - 1);
  assign done_nx = done + CNT_W'(1);
  assign is_inc = state == INC && !reset;
  assign is_rcap = state == RCAP && !reset;
  assign st_push = state == STATUS && tx_ok;
  assign rx_fifo_rd_en = pop;
  assign reg_num_le = (state == ADDR && pop) || is_inc;
  assign reg_wr_en = state == WDATA && pop;
  assign reg_rd_en = state == RD && tx_ok;
  assign reg_rx_data = (state == ADDR || state == WDATA) && pop ? rx_fifo_data : is_inc ? cur + 32'd1 : 32'd0;
  assign tx_fifo_wr_en = is_rcap || st_push;
  assign tx_fifo_data = is_rcap ? reg_tx_data : st_push ? {8'hC0, op, 2'b00, err, 16'(done)} : 32'd0;
  assign cmd_error = st_push && |err;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      n <= '0;
      done <= '0;
      left <= '0;
      cur <= '0;
      err <= '0;
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= pop ? TW'(1) : (state == IDLE || state == STATUS) ? '0 :
                 tmo_cnt == TW'(TIMEOUT_CYCLES) ? tmo_cnt : tmo_cnt + TW'(1);
      case (state)
        IDLE: if (pop) begin
          op <= rx_fifo_data[31:30];
          n <= rx_fifo_data[CNT_W-1:0];
          done <= '0;
          if (rx_fifo_data[31:30] != 2'b01 && rx_fifo_data[31:30] != 2'b10) begin
            err <= 4'b0100;
            state <= STATUS;
          end else if (rx_fifo_data[CNT_W-1:0] == '0) begin
            err <= 4'b1000;
            state <= STATUS;
          end else state <= ADDR;
        end
        ADDR: if (pop) begin
          cur <= rx_fifo_data;
          state <= CHECK;
        end else if (tmo) begin
          err[1] <= 1'b1;
          state <= STATUS;
        end
        CHECK: if (reg_illegal_num) begin
          err[0] <= 1'b1;
          left <= n - done;
          state <= op == 2'b01 ? FLUSH : STATUS;
        end else state <= op == 2'b01 ? WDATA : RD;
        WDATA: if (pop) begin
          done <= done_nx;
          state <= done_nx == n ? STATUS : INC;
        end else if (tmo) begin
          err[1] <= 1'b1;
          state <= STATUS;
        end
        INC: begin
          cur <= cur + 32'd1;
          state <= CHECK;
        end
        RD: if (tx_ok) state <= RCAP;
        RCAP: begin
          done <= done_nx;
          state <= done_nx == n ? STATUS : INC;
        end
        FLUSH: if (pop) begin
          left <= left - CNT_W'(1);
          if (left == CNT_W'(1)) state <= STATUS;
        end else if (tmo) begin
          err[1] <= 1'b1;
          state <= STATUS;
        end
        STATUS: if (tx_ok) begin
          err <= '0;
          done <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
